// File: rtl/alib_hash_lookup_if.sv
// Request/response bundle for the hash lookup table.
// The requester drives req_valid/op/key/value; the table returns ready and the response strobe.
interface alib_hash_lookup_if #(
  parameter int KEY_WIDTH   = 32,
  parameter int VALUE_WIDTH = 16
);
  logic                   req_valid;
  logic                   req_ready;
  logic [1:0]             req_op;
  logic [KEY_WIDTH-1:0]   req_key;
  logic [VALUE_WIDTH-1:0] req_value;
  logic                   rsp_valid;
  logic                   rsp_hit;
  logic [VALUE_WIDTH-1:0] rsp_value;
  logic                   rsp_evict;

  modport master (
    output req_valid, req_op, req_key, req_value,
    input  req_ready, rsp_valid, rsp_hit, rsp_value, rsp_evict
  );

  modport slave (
    input  req_valid, req_op, req_key, req_value,
    output req_ready, rsp_valid, rsp_hit, rsp_value, rsp_evict
  );
endinterface

// File: rtl/alib_hash_lookup.sv
// Direct-mapped key/value hash table with full-key tags, lookup/insert/delete,
// fixed two-cycle response, hardware invalidate sweep and a live occupancy count.
module alib_hash_lookup #(
  parameter int HASH_BITS   = 15,
  parameter int KEY_WIDTH   = 32,
  parameter int VALUE_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  alib_hash_lookup_if.slave    bus,
  output logic                 clear_busy,
  output logic [HASH_BITS:0]   occupancy
);

  localparam int DEPTH = 1 << HASH_BITS;
  localparam logic [HASH_BITS-1:0] IDX_ONE = 1;
  localparam logic [HASH_BITS:0]   OCC_ONE = 1;

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_READ, ST_RESP} state_e;
  typedef enum logic [1:0] {
    OP_LOOKUP = 2'b00,
    OP_INSERT = 2'b01,
    OP_DELETE = 2'b10,
    OP_ALIAS  = 2'b11   // behaves as a lookup
  } op_e;

  typedef struct packed {
    logic                   valid;
    logic [KEY_WIDTH-1:0]   tag;
    logic [VALUE_WIDTH-1:0] value;
  } entry_t;

  // Multiplicative (Fibonacci) hash: the top bits of the 32-bit product are the best mixed.
  function automatic logic [HASH_BITS-1:0] hash_index(input logic [KEY_WIDTH-1:0] key);
    logic [31:0] key32;
    logic [31:0] prod;
    key32                = '0;
    key32[KEY_WIDTH-1:0] = key;
    prod                 = key32 * 32'h9E3779B1;
    return prod[31 -: HASH_BITS];
  endfunction

  state_e                 state_q, state_d;
  logic [HASH_BITS-1:0]   clr_idx_q, clr_idx_d;
  logic                   pending_q, pending_d;
  op_e                    op_q, op_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [VALUE_WIDTH-1:0] value_q, value_d;
  logic [HASH_BITS-1:0]   idx_q, idx_d;
  logic [HASH_BITS:0]     occ_q, occ_d;

  entry_t                 mem_q [DEPTH];
  entry_t                 rd_q;
  logic                   mem_we;
  logic [HASH_BITS-1:0]   mem_waddr;
  entry_t                 mem_wdata;

  logic accept;
  logic hit_raw;
  logic evict_raw;

  assign accept    = bus.req_valid && bus.req_ready;
  assign hit_raw   = rd_q.valid && (rd_q.tag == key_q);
  assign evict_raw = (op_q == OP_INSERT) && rd_q.valid && (rd_q.tag != key_q);
  assign occupancy = occ_q;

  // State register and request capture; reset drops any in-flight operation.
  // NOTE: the reset is synchronous, so it lives inside the clocked branch, and all
  // state uses <= so every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      pending_q <= 1'b0;
      op_q      <= OP_LOOKUP;
      key_q     <= '0;
      value_q   <= '0;
      idx_q     <= '0;
      occ_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      pending_q <= pending_d;
      op_q      <= op_d;
      key_q     <= key_d;
      value_q   <= value_d;
      idx_q     <= idx_d;
      occ_q     <= occ_d;
    end
  end

  // Table storage: one write port (sweep or RESP update) and one synchronous read in READ.
  // NOTE: the array is deliberately not reset; the hardware sweep invalidates it instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    if (state_q == ST_READ) rd_q <= mem_q[idx_q];
  end

  // Next-state, sweep index, pending clear, request latch and occupancy update.
  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    pending_d = pending_q;
    op_d      = op_q;
    key_d     = key_q;
    value_d   = value_q;
    idx_d     = idx_q;
    occ_d     = occ_q;

    case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + IDX_ONE;
        if (clr_idx_q == '1) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (clear)       state_d = ST_CLEAR;
        else if (accept) state_d = ST_READ;
      end
      ST_READ: begin
        if (clear) pending_d = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (op_q == OP_INSERT && !rd_q.valid)  occ_d = occ_q + OCC_ONE;
        else if (op_q == OP_DELETE && hit_raw) occ_d = occ_q - OCC_ONE;
        if (clear || pending_q) state_d = ST_CLEAR;
        else if (accept)        state_d = ST_READ;
        else                    state_d = ST_IDLE;
      end
      default: state_d = ST_CLEAR;
    endcase

    if (accept) begin
      op_d    = op_e'(bus.req_op);
      key_d   = bus.req_key;
      value_d = bus.req_value;
      idx_d   = hash_index(bus.req_key);
    end

    // Entering the sweep always starts from index 0 with an empty table.
    if (state_d == ST_CLEAR && state_q != ST_CLEAR) begin
      occ_d     = '0;
      pending_d = 1'b0;
      clr_idx_d = '0;
    end
  end

  // Memory write selection: sweep invalidate, insert overwrite, or delete on hit.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = idx_q;
    mem_wdata = '0;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
      end
      ST_RESP: begin
        if (op_q == OP_INSERT) begin
          mem_we    = 1'b1;
          mem_wdata = '{valid: 1'b1, tag: key_q, value: value_q};
        end else if (op_q == OP_DELETE && hit_raw) begin
          mem_we    = 1'b1;
        end
      end
      default: ;
    endcase
    // An operation caught by reset must leave the table untouched.
    if (!reset_n) mem_we = 1'b0;
  end

  // Handshake and response outputs; response fields are zero outside the strobe.
  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_hit   = 1'b0;
    bus.rsp_value = '0;
    bus.rsp_evict = 1'b0;
    clear_busy    = 1'b0;
    case (state_q)
      ST_CLEAR: clear_busy = 1'b1;
      ST_IDLE:  bus.req_ready = !clear;
      ST_RESP: begin
        bus.req_ready = !clear && !pending_q;
        bus.rsp_valid = 1'b1;
        bus.rsp_hit   = hit_raw;
        bus.rsp_evict = evict_raw;
        // An evicting insert reports the value it displaced; any other miss reports 0.
        if (hit_raw || evict_raw) bus.rsp_value = rd_q.value;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alib_hash_lookup.sv
// Directed bench for alib_hash_lookup with a 16-entry table (HASH_BITS=4).
// Index map used below: key0->0, key13->0, key1->9, key2->3, key5->1, key7->5.
module tb_alib_hash_lookup;
  localparam int HB = 4;
  localparam int KW = 32;
  localparam int VW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear = 1'b0;
  logic          clear_busy;
  logic [HB:0]   occupancy;

  int tests  = 0;
  int failed = 0;

  alib_hash_lookup_if #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW)) bus ();

  alib_hash_lookup #(.HASH_BITS(HB), .KEY_WIDTH(KW), .VALUE_WIDTH(VW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .bus        (bus),
    .clear_busy (clear_busy),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request from an IDLE negedge; returns at the RESP-cycle negedge.
  task automatic txn(input logic [1:0] op, input logic [31:0] key, input logic [15:0] val,
                     output logic hit, output logic [15:0] v, output logic ev);
    int n;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_key   = key;
    bus.req_value = val;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(n < 40), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 1;
    while (bus.rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'd2);
    hit = bus.rsp_hit;
    v   = bus.rsp_value;
    ev  = bus.rsp_evict;
  endtask

  // Step past RESP: strobe must be gone and occupancy updated.
  task automatic post(input string tag, input int occ_exp);
    @(negedge clk);
    check({tag, "_strobe_low"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_occ"}, 32'(occupancy), 32'(occ_exp));
  endtask

  // Count sampled cycles with clear_busy high, optionally pulsing clear mid-sweep.
  task automatic count_busy(input int clr_at, output int n, output logic saw_rsp);
    n = 0;
    saw_rsp = 1'b0;
    while (clear_busy === 1'b1 && n < 100) begin
      if (bus.rsp_valid !== 1'b0) saw_rsp = 1'b1;
      clear = (n == clr_at);
      @(negedge clk);
      n++;
    end
    clear = 1'b0;
  endtask

  logic        hit, ev, saw;
  logic [15:0] v;
  int          n;
  time         t1, t2;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_key   = '0;
    bus.req_value = '0;

    // 1. Reset state and initial sweep
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_busy", 32'(clear_busy), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    reset_n = 1'b1;
    count_busy(-1, n, saw);
    check("init_sweep_len", 32'(n), 32'd16);
    check("ready_after_sweep", 32'(bus.req_ready), 32'd1);
    txn(2'b00, 32'd5, 16'h0, hit, v, ev);
    check("t1_hit", 32'(hit), 32'd0);
    check("t1_value", 32'(v), 32'd0);
    post("t1", 0);

    // 2. Insert then lookup key 1
    txn(2'b01, 32'd1, 16'h00AB, hit, v, ev);
    check("t2_ins_hit", 32'(hit), 32'd0);
    check("t2_ins_evict", 32'(ev), 32'd0);
    post("t2_ins", 1);
    txn(2'b00, 32'd1, 16'h0, hit, v, ev);
    check("t2_lk_hit", 32'(hit), 32'd1);
    check("t2_lk_value", 32'(v), 32'h00AB);
    post("t2_lk", 1);
    txn(2'b11, 32'd1, 16'h0, hit, v, ev);
    check("t2_op3_hit", 32'(hit), 32'd1);
    check("t2_op3_value", 32'(v), 32'h00AB);
    post("t2_op3", 1);

    // 3. Collision at index 0: key 13 evicts key 0
    txn(2'b01, 32'd0, 16'h0011, hit, v, ev);
    check("t3_ins0_evict", 32'(ev), 32'd0);
    post("t3_ins0", 2);
    txn(2'b01, 32'd13, 16'h0022, hit, v, ev);
    check("t3_ins13_hit", 32'(hit), 32'd0);
    check("t3_ins13_evict", 32'(ev), 32'd1);
    check("t3_ins13_value", 32'(v), 32'h0011);
    post("t3_ins13", 2);
    txn(2'b00, 32'd0, 16'h0, hit, v, ev);
    check("t3_lk0_hit", 32'(hit), 32'd0);
    check("t3_lk0_value", 32'(v), 32'd0);
    post("t3_lk0", 2);
    txn(2'b00, 32'd13, 16'h0, hit, v, ev);
    check("t3_lk13_hit", 32'(hit), 32'd1);
    check("t3_lk13_value", 32'(v), 32'h0022);
    post("t3_lk13", 2);
    txn(2'b01, 32'd13, 16'h0044, hit, v, ev);
    check("t3_upd_hit", 32'(hit), 32'd1);
    check("t3_upd_value", 32'(v), 32'h0022);
    check("t3_upd_evict", 32'(ev), 32'd0);
    post("t3_upd", 2);
    txn(2'b10, 32'd0, 16'h0, hit, v, ev);
    check("t3_delmiss_hit", 32'(hit), 32'd0);
    post("t3_delmiss", 2);
    txn(2'b00, 32'd13, 16'h0, hit, v, ev);
    check("t3_lk13b_value", 32'(v), 32'h0044);
    post("t3_lk13b", 2);

    // 4. Back-to-back insert/delete of key 2 with req_valid held
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    bus.req_key   = 32'd2;
    bus.req_value = 16'h0033;
    check("t4_ready1", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    t1 = $time;
    @(negedge clk);
    bus.req_op    = 2'b10;
    bus.req_value = 16'h0;
    check("t4_read_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("t4_ins_valid", 32'(bus.rsp_valid), 32'd1);
    check("t4_ins_hit", 32'(bus.rsp_hit), 32'd0);
    check("t4_resp_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    t2 = $time;
    check("t4_gap", 32'((t2 - t1) / 10), 32'd2);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("t4_occ_mid", 32'(occupancy), 32'd3);
    @(negedge clk);
    check("t4_del_valid", 32'(bus.rsp_valid), 32'd1);
    check("t4_del_hit", 32'(bus.rsp_hit), 32'd1);
    check("t4_del_value", 32'(bus.rsp_value), 32'h0033);
    post("t4_del", 2);
    txn(2'b00, 32'd2, 16'h0, hit, v, ev);
    check("t4_lk_hit", 32'(hit), 32'd0);
    post("t4_lk", 2);

    // 5. Clear pulse during the READ cycle of a lookup
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    bus.req_key   = 32'd1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("t5_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("t5_rsp_hit", 32'(bus.rsp_hit), 32'd1);
    check("t5_rsp_value", 32'(bus.rsp_value), 32'h00AB);
    check("t5_ready_pending", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("t5_occ_zero", 32'(occupancy), 32'd0);
    count_busy(3, n, saw);
    check("t5_sweep_len", 32'(n), 32'd16);
    check("t5_ready", 32'(bus.req_ready), 32'd1);
    txn(2'b00, 32'd1, 16'h0, hit, v, ev);
    check("t5_lk1_hit", 32'(hit), 32'd0);
    post("t5_lk1", 0);
    txn(2'b00, 32'd13, 16'h0, hit, v, ev);
    check("t5_lk13_hit", 32'(hit), 32'd0);
    check("t5_lk13_value", 32'(v), 32'd0);
    post("t5_lk13", 0);

    // 6. Reset during the READ cycle of an insert
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    bus.req_key   = 32'd7;
    bus.req_value = 16'h0077;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("t6_no_rsp", 32'(bus.rsp_valid), 32'd0);
    check("t6_busy", 32'(clear_busy), 32'd1);
    check("t6_occ", 32'(occupancy), 32'd0);
    count_busy(-1, n, saw);
    check("t6_sweep_len", 32'(n), 32'd16);
    check("t6_saw_rsp", 32'(saw), 32'd0);
    txn(2'b00, 32'd7, 16'h0, hit, v, ev);
    check("t6_lk7_hit", 32'(hit), 32'd0);
    post("t6_lk7", 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
